// File: rtl/demux16x8_regbank_if.sv
// Write-back / issue bus of the register bank, with its registered read-out side.
interface demux16x8_regbank_if;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        busy_set;
  logic [2:0]  busy_sel;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] data3;
  logic [15:0] data4;
  logic [15:0] data5;
  logic [15:0] data6;
  logic [15:0] data7;
  logic [7:0]  busy;
  logic [7:0]  wr_strobe;
  logic        err_unexpected;

  modport master (
    output wr_en, wr_sel, wr_data, wr_be, busy_set, busy_sel,
    input  data0, data1, data2, data3, data4, data5, data6, data7,
    input  busy, wr_strobe, err_unexpected
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, wr_be, busy_set, busy_sel,
    output data0, data1, data2, data3, data4, data5, data6, data7,
    output busy, wr_strobe, err_unexpected
  );
endinterface

// File: rtl/demux16x8_regbank.sv
// 1-to-8 write-back demux into eight 16-bit registers with byte enables,
// a busy scoreboard, one-cycle write strobes and a sticky protocol-error flag.
module demux16x8_regbank #(
  parameter logic [15:0] RESET_VALUE = 16'h0000,
  parameter bit          CHECK_BUSY  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  demux16x8_regbank_if.slave   bus
);

  localparam int unsigned NREG  = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned BYTEW = 8;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] dsel;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [DW-1:0]   be_mask;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] strobe_q;
  logic            err_q;

  // Decode destination / issue selects and expand byte enables to a bit mask.
  always_comb begin
    dsel    = NREG'(1) << bus.wr_sel;
    clr_vec = bus.wr_en ? dsel : '0;
    set_vec = bus.busy_set ? (NREG'(1) << bus.busy_sel) : '0;
    be_mask = {{BYTEW{bus.wr_be[1]}}, {BYTEW{bus.wr_be[0]}}};
  end

  // Register file: only enabled lanes of the selected register take new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (clr_vec[i]) regs[i] <= (regs[i] & ~be_mask) | (bus.wr_data & be_mask);
      end
    end
  end

  // Strobe pulses with the updated data; scoreboard lets a same-cycle set beat the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= '0;
      busy_q   <= '0;
    end else begin
      strobe_q <= clr_vec;
      busy_q   <= set_vec | (busy_q & ~clr_vec);
    end
  end

  generate
    if (CHECK_BUSY) begin : g_err
      // Sticky error on write-back to a register not marked busy before this edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_q | (bus.wr_en & ~busy_q[bus.wr_sel]);
      end
    end else begin : g_noerr
      // Error checking disabled: flag held low.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= 1'b0;
      end
    end
  endgenerate

  assign bus.data0          = regs[0];
  assign bus.data1          = regs[1];
  assign bus.data2          = regs[2];
  assign bus.data3          = regs[3];
  assign bus.data4          = regs[4];
  assign bus.data5          = regs[5];
  assign bus.data6          = regs[6];
  assign bus.data7          = regs[7];
  assign bus.busy           = busy_q;
  assign bus.wr_strobe      = strobe_q;
  assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_demux16x8_regbank.sv
// Self-checking bench: directed steps plus random traffic against a byte-level model.
module tb_demux16x8_regbank;

  logic clk;
  logic reset;

  demux16x8_regbank_if bus ();
  demux16x8_regbank_if bus2 ();

  demux16x8_regbank #(.RESET_VALUE(16'h0000), .CHECK_BUSY(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  demux16x8_regbank #(.RESET_VALUE(16'h0000), .CHECK_BUSY(1'b0)) dut_nochk (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  assign bus2.wr_en    = bus.wr_en;
  assign bus2.wr_sel   = bus.wr_sel;
  assign bus2.wr_data  = bus.wr_data;
  assign bus2.wr_be    = bus.wr_be;
  assign bus2.busy_set = bus.busy_set;
  assign bus2.busy_sel = bus.busy_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: each register held as two independent bytes.
  logic [7:0] m_lo [8];
  logic [7:0] m_hi [8];
  bit   [7:0] m_busy;
  bit   [7:0] m_strobe;
  bit         m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lo[i] = 8'h00;
      m_hi[i] = 8'h00;
    end
    m_busy   = 8'h00;
    m_strobe = 8'h00;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    int k;
    if (reset) begin
      model_reset();
    end else begin
      m_strobe = 8'h00;
      if (bus.wr_en) begin
        k = int'(bus.wr_sel);
        if (m_busy[k] == 1'b0) m_err = 1'b1;
        if (bus.wr_be[0]) m_lo[k] = bus.wr_data[7:0];
        if (bus.wr_be[1]) m_hi[k] = bus.wr_data[15:8];
        m_strobe[k] = 1'b1;
        m_busy[k]   = 1'b0;
      end
      if (bus.busy_set) m_busy[int'(bus.busy_sel)] = 1'b1;
    end
  endtask

  function automatic logic [15:0] rd(input bit second, input int k);
    logic [15:0] v;
    case (k)
      0: v = second ? bus2.data0 : bus.data0;
      1: v = second ? bus2.data1 : bus.data1;
      2: v = second ? bus2.data2 : bus.data2;
      3: v = second ? bus2.data3 : bus.data3;
      4: v = second ? bus2.data4 : bus.data4;
      5: v = second ? bus2.data5 : bus.data5;
      6: v = second ? bus2.data6 : bus.data6;
      default: v = second ? bus2.data7 : bus.data7;
    endcase
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s data%0d", tag, i), rd(1'b0, i), {m_hi[i], m_lo[i]});
      check_eq($sformatf("%s nochk data%0d", tag, i), rd(1'b1, i), {m_hi[i], m_lo[i]});
    end
    check_eq({tag, " busy"}, 16'(bus.busy), 16'(m_busy));
    check_eq({tag, " strobe"}, 16'(bus.wr_strobe), 16'(m_strobe));
    check_eq({tag, " err"}, 16'(bus.err_unexpected), 16'(m_err));
    check_eq({tag, " nochk busy"}, 16'(bus2.busy), 16'(m_busy));
    check_eq({tag, " nochk strobe"}, 16'(bus2.wr_strobe), 16'(m_strobe));
    check_eq({tag, " nochk err"}, 16'(bus2.err_unexpected), 16'h0000);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit en, input int sel, input logic [15:0] d, input logic [1:0] be,
                       input bit bset, input int bsel);
    bus.wr_en    = en;
    bus.wr_sel   = 3'(sel);
    bus.wr_data  = d;
    bus.wr_be    = be;
    bus.busy_set = bset;
    bus.busy_sel = 3'(bsel);
  endtask

  task automatic idle();
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b0, 0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    drive(1'b1, 3, 16'hBEEF, 2'b11, 1'b0, 0);
    #1;

    // Reset held with a write pending: everything stays at reset values.
    step("rst1");
    step("rst2");
    check_eq("rst data3", bus.data3, 16'h0000);

    // Load data5 then assert reset asynchronously mid-cycle.
    reset = 1'b0;
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 5);
    step("ld5 set");
    drive(1'b1, 5, 16'h1234, 2'b11, 1'b0, 0);
    step("ld5 wr");
    check_eq("ld5 value", bus.data5, 16'h1234);
    idle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async rst");
    check_eq("async rst data5", bus.data5, 16'h0000);
    step("async rst hold");
    reset = 1'b0;

    // Full sweep: mark all busy, then write each register.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, i);
      step("sweep set");
    end
    check_eq("sweep busy all", 16'(bus.busy), 16'h00FF);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 16'(16'h1111 * i), 2'b11, 1'b0, 0);
      step("sweep wr");
      check_eq("sweep strobe", 16'(bus.wr_strobe), 16'(8'(1) << i));
    end
    idle();
    step("sweep idle");
    check_eq("sweep strobe off", 16'(bus.wr_strobe), 16'h0000);
    check_eq("sweep data7", bus.data7, 16'h7777);

    // Byte lanes on register 2, busy re-issued alongside each write.
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 2);
    step("lane set");
    drive(1'b1, 2, 16'hAAAA, 2'b11, 1'b1, 2);
    step("lane aaaa");
    drive(1'b1, 2, 16'h1234, 2'b01, 1'b1, 2);
    step("lane be01");
    check_eq("lane aa34", bus.data2, 16'hAA34);
    drive(1'b1, 2, 16'h1234, 2'b10, 1'b1, 2);
    step("lane be10");
    check_eq("lane 1234", bus.data2, 16'h1234);
    drive(1'b1, 2, 16'hFFFF, 2'b00, 1'b0, 0);
    step("lane be00");
    check_eq("lane hold", bus.data2, 16'h1234);
    check_eq("lane strobe", 16'(bus.wr_strobe), 16'h0004);

    // Scoreboard collision: set and clear on register 4 in one cycle.
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 4);
    step("coll set4");
    drive(1'b1, 4, 16'h4444, 2'b11, 1'b1, 4);
    step("coll wr4");
    check_eq("coll busy4", 16'(bus.busy), 16'h0010);
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 1);
    step("coll set1");
    drive(1'b1, 1, 16'hA1A1, 2'b11, 1'b1, 6);
    step("coll wr1 set6");
    check_eq("coll busy50", 16'(bus.busy), 16'h0050);
    drive(1'b1, 4, 16'h0404, 2'b11, 1'b0, 0);
    step("coll wr4b");

    // Back-to-back writes 3, 3, 5.
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 3);
    step("b2b set3");
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 5);
    step("b2b set5");
    drive(1'b1, 3, 16'h3333, 2'b11, 1'b1, 3);
    step("b2b wr3a");
    check_eq("b2b s1", 16'(bus.wr_strobe), 16'h0008);
    drive(1'b1, 3, 16'h3C3C, 2'b11, 1'b0, 0);
    step("b2b wr3b");
    check_eq("b2b s2", 16'(bus.wr_strobe), 16'h0008);
    drive(1'b1, 5, 16'h5A5A, 2'b11, 1'b0, 0);
    step("b2b wr5");
    check_eq("b2b s3", 16'(bus.wr_strobe), 16'h0020);
    idle();
    step("b2b idle");
    check_eq("b2b s4", 16'(bus.wr_strobe), 16'h0000);
    check_eq("b2b data3", bus.data3, 16'h3C3C);
    check_eq("b2b err clean", 16'(bus.err_unexpected), 16'h0000);

    // Drain register 6 so nothing is busy, then make an illegal write to 7.
    drive(1'b1, 6, 16'h6666, 2'b11, 1'b0, 0);
    step("err drain6");
    check_eq("err busy0", 16'(bus.busy), 16'h0000);
    drive(1'b1, 7, 16'h7E7E, 2'b11, 1'b0, 0);
    step("err wr7");
    check_eq("err set", 16'(bus.err_unexpected), 16'h0001);
    check_eq("err data7", bus.data7, 16'h7E7E);
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 0);
    step("err legal set");
    drive(1'b1, 0, 16'h0F0F, 2'b11, 1'b0, 0);
    step("err legal wr");
    check_eq("err sticky", 16'(bus.err_unexpected), 16'h0001);

    // Random traffic; both illegal and legal write-backs occur.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      step("rand");
    end

    // Reset clears the sticky error.
    idle();
    reset = 1'b1;
    step("final rst");
    reset = 1'b0;
    step("final idle");
    check_eq("final err", 16'(bus.err_unexpected), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
